// File: rtl/sdram_responder.sv
// Behavioural SDRAM target: decodes the command bus, models a 4-bank 16-bit array,
// returns read data after CAS latency and flags protocol errors. Define
// SDRAM_RESPONDER_TIMING_CHECK_EN to add per-bank ACTIVE-to-READ/WRITE (tRCD) checking.
module sdram_responder #(
  parameter int ROW_W = 3,
  parameter int COL_W = 8,
  parameter int TRCD  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sdram_ncs,
  input  logic        sdram_nras,
  input  logic        sdram_ncas,
  input  logic        sdram_nwe,
  input  logic [12:0] sdram_a,
  input  logic [1:0]  sdram_ba,
  input  logic        sdram_dqml,
  input  logic        sdram_dqmh,
  input  logic [15:0] dq_in,
  output logic [15:0] dq_out,
  output logic [1:0]  dq_oe,
  output logic        protocol_err,
  output logic [2:0]  err_code,
  output logic [15:0] refresh_cnt
);
  localparam int AW = 2 + ROW_W + COL_W;

  typedef enum logic [3:0] {
    C_INH, C_NOP, C_ACT, C_RD, C_WR, C_BT, C_PRE, C_REF, C_LMR
  } cmd_e;

  cmd_e                   cmd;
  logic [3:0]             open_q, open_d;
  logic [3:0][ROW_W-1:0]  row_q, row_d;
  logic [2:0]             cl_q, cl_d;
  logic                   mode_ok_q, mode_ok_d;
  logic [15:0]            ref_q, ref_d;
  logic                   perr_q;
  logic [2:0]             code_q, err;
  logic                   rd_go, wr_go, wr_cmd, trcd_ok;
  logic [AW-1:0]          addr;
  logic [15:0]            mem_q [2**AW];

  // Read pipeline: stage 1 holds the fetched word, stage 2 only carries CL=3 reads.
  logic                   s1_v_q, s1_cl2_q, s2_v_q;
  logic [1:0]             s1_m_q, s2_m_q, oe_q;
  logic [15:0]            s1_dat_q, s2_dat_q, dout_q;

  logic unused_a;
  assign unused_a = ^sdram_a;

  always_comb begin
    cmd = C_INH;
    if (!sdram_ncs) begin
      case ({sdram_nras, sdram_ncas, sdram_nwe})
        3'b111:  cmd = C_NOP;
        3'b011:  cmd = C_ACT;
        3'b101:  cmd = C_RD;
        3'b100:  cmd = C_WR;
        3'b110:  cmd = C_BT;
        3'b010:  cmd = C_PRE;
        3'b001:  cmd = C_REF;
        default: cmd = C_LMR;
      endcase
    end
  end

  assign addr   = {sdram_ba, row_q[sdram_ba], sdram_a[COL_W-1:0]};
  assign wr_cmd = (cmd == C_WR);

`ifdef SDRAM_RESPONDER_TIMING_CHECK_EN
  localparam logic [7:0] RCD_LOAD = 8'(TRCD > 0 ? TRCD - 1 : 0);
  logic [3:0][7:0] rcd_q, rcd_d;
  logic            act_go;

  assign act_go  = (cmd == C_ACT) && !open_q[sdram_ba];
  assign trcd_ok = (rcd_q[sdram_ba] == 8'd0);

  always_comb begin
    for (int b = 0; b < 4; b++)
      rcd_d[b] = (rcd_q[b] != 8'd0) ? rcd_q[b] - 8'd1 : 8'd0;
    if (act_go) rcd_d[sdram_ba] = RCD_LOAD;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) rcd_q <= '0;
    else       rcd_q <= rcd_d;
`else
  assign trcd_ok = 1'b1;
`endif

  always_comb begin
    open_d    = open_q;
    row_d     = row_q;
    cl_d      = cl_q;
    mode_ok_d = mode_ok_q;
    ref_d     = ref_q;
    err       = 3'd0;
    rd_go     = 1'b0;
    wr_go     = 1'b0;
    case (cmd)
      C_ACT: begin
        if (open_q[sdram_ba]) err = 3'd1;
        else begin
          open_d[sdram_ba] = 1'b1;
          row_d[sdram_ba]  = sdram_a[ROW_W-1:0];
        end
      end
      C_RD, C_WR: begin
        if (!open_q[sdram_ba]) err = 3'd2;
        else if (!mode_ok_q)   err = 3'd3;
        else if (!trcd_ok)     err = 3'd6;
        else begin
          rd_go = (cmd == C_RD);
          wr_go = (cmd == C_WR);
          if (sdram_a[10]) open_d[sdram_ba] = 1'b0;
        end
      end
      C_BT:  err = 3'd7;
      C_PRE: begin
        if (sdram_a[10]) open_d = '0;
        else             open_d[sdram_ba] = 1'b0;
      end
      C_REF: begin
        if (|open_q) err = 3'd4;
        else         ref_d = ref_q + 16'd1;
      end
      C_LMR: begin
        cl_d      = sdram_a[6:4];
        mode_ok_d = (sdram_a[6:4] == 3'd2 || sdram_a[6:4] == 3'd3) && (sdram_a[2:0] == 3'd0);
        if (!mode_ok_d) err = 3'd5;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      open_q    <= '0;
      row_q     <= '0;
      cl_q      <= 3'd0;
      mode_ok_q <= 1'b0;
      ref_q     <= 16'd0;
      perr_q    <= 1'b0;
      code_q    <= 3'd0;
    end else begin
      open_q    <= open_d;
      row_q     <= row_d;
      cl_q      <= cl_d;
      mode_ok_q <= mode_ok_d;
      ref_q     <= ref_d;
      if (err != 3'd0) begin
        perr_q <= 1'b1;
        if (!perr_q) code_q <= err;
      end
    end
  end

  // Any WRITE on the bus kills every read still in flight, including one due this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v_q   <= 1'b0;
      s1_cl2_q <= 1'b0;
      s1_m_q   <= 2'b00;
      s1_dat_q <= 16'd0;
      s2_v_q   <= 1'b0;
      s2_m_q   <= 2'b00;
      s2_dat_q <= 16'd0;
      dout_q   <= 16'd0;
      oe_q     <= 2'b00;
    end else begin
      s1_v_q   <= rd_go;
      s1_cl2_q <= (cl_q == 3'd2);
      s1_m_q   <= {sdram_dqmh, sdram_dqml};
      s1_dat_q <= mem_q[addr];
      s2_v_q   <= s1_v_q && !s1_cl2_q && !wr_cmd;
      s2_m_q   <= {sdram_dqmh, sdram_dqml};
      s2_dat_q <= s1_dat_q;
      dout_q   <= 16'd0;
      oe_q     <= 2'b00;
      if (!wr_cmd) begin
        if (s2_v_q) begin
          dout_q <= s2_dat_q;
          oe_q   <= ~s2_m_q;
        end else if (s1_v_q && s1_cl2_q) begin
          dout_q <= s1_dat_q;
          oe_q   <= ~s1_m_q;
        end
      end
    end
  end

  // Array is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_go) begin
      if (!sdram_dqmh) mem_q[addr][15:8] <= dq_in[15:8];
      if (!sdram_dqml) mem_q[addr][7:0]  <= dq_in[7:0];
    end
  end

  assign dq_out       = dout_q;
  assign dq_oe        = oe_q;
  assign protocol_err = perr_q;
  assign err_code     = code_q;
  assign refresh_cnt  = ref_q;

endmodule
